packet_spi_tx: RTL and testbench

Serialising transmitter for one router packet (destination, data, checksum) onto an SPI master link, mode 0 (CPOL=0, CPHA=0), MSB first. It is the outbound counterpart to the switch/push-button packet capture stage. It accepts a packet on a single-cycle `start` strobe, frames it under `csN`, and reports completion with a one-cycle `done` pulse. Sits between the router output registers and the off-board SPI pins.

---
 rtl/packet_spi_tx_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 48 ++++
 rtl/packet_spi_tx.sv | 167 ++++++++++++++++
 tb/tb_packet_spi_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_spi_tx_pkg.sv
// Shared definitions for the packet SPI transmitter.
//   state_t    : frame sequencer states
//   frame_bits : serial frame length for a given field width
//                (destination + data + checksum, checksum one bit wider)
package packet_spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } state_t;

  function automatic int unsigned frame_bits(input int unsigned size);
    return 3 * size + 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing generator for the packet SPI transmitter.
// Counts CLK_DIV system clocks per SCLK half-period and flags the last
// cycle of each half with a one-cycle strobe.
//   clock     : system clock
//   reset     : synchronous, active-high
//   en        : advance the divider
//   clr       : restart at the beginning of a low half (wins over en)
//   rise_tick : last cycle of a low half; SCLK rises on the next edge
//   fall_tick : last cycle of a high half; SCLK falls on the next edge
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;
  logic          phase;   // 0: low half, 1: high half
  logic          wrap;

  always_comb begin
    wrap      = en && (count == LAST);
    rise_tick = wrap && !phase;
    fall_tick = wrap && phase;
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_spi_tx.sv
// Serialising SPI master (mode 0, MSB first) for one router packet.
// Frame = {destination, data, checkSum}, sent under csN with CLK_DIV setup
// before the first SCLK rise and CLK_DIV hold after the last fall.
//   clock, reset : system clock, synchronous active-high reset
//   start        : send request, accepted while busy is low (incl. DONE)
//   destination, data, checkSum : packet fields, captured on accepted start
//   busy         : frame in progress (LEAD/SHIFT/TRAIL)
//   done         : one-cycle pulse after csN returns high
//   sclk, mosi, csN : SPI pins
module packet_spi_tx
  import packet_spi_tx_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] destination,
  input  logic [SIZE-1:0] data,
  input  logic [SIZE:0]   checkSum,
  output logic            busy,
  output logic            done,
  output logic            sclk,
  output logic            mosi,
  output logic            csN
);

  localparam int unsigned FRAME_BITS = frame_bits(SIZE);
  localparam int unsigned BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  state_t                state;
  state_t                state_next;
  logic [FRAME_BITS-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic                  sclk_q;

  logic div_en;
  logic div_clr;
  logic rise_tick;
  logic fall_tick;
  logic load;
  logic shift;
  logic bit_step;
  logic last_bit;
  logic sclk_set;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clock    (clock),
    .reset    (reset),
    .en       (div_en),
    .clr      (div_clr),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // LEAD and TRAIL reuse the divider's low-half strobe as their CLK_DIV
  // cycle timer; the divider is cleared leaving LEAD so SHIFT starts on a
  // fresh low half. SHIFT ends on a fall, which already leaves it at the
  // start of a low half for TRAIL.
  always_comb begin
    state_next = state;
    div_en     = 1'b0;
    div_clr    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    bit_step   = 1'b0;
    sclk_set   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    csN        = 1'b1;
    last_bit   = (bit_cnt == LAST_BIT);
    unique case (state)
      IDLE: begin
        div_clr = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = LEAD;
        end
      end
      LEAD: begin
        busy   = 1'b1;
        csN    = 1'b0;
        div_en = 1'b1;
        if (rise_tick) begin
          div_clr    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        csN      = 1'b0;
        div_en   = 1'b1;
        sclk_set = rise_tick;
        if (fall_tick) begin
          bit_step = 1'b1;
          // The last bit is left on mosi through TRAIL.
          if (last_bit) begin
            state_next = TRAIL;
          end else begin
            shift = 1'b1;
          end
        end
      end
      TRAIL: begin
        busy   = 1'b1;
        csN    = 1'b0;
        div_en = 1'b1;
        if (rise_tick) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        div_clr = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = LEAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
    end else if (load) begin
      shreg   <= {destination, data, checkSum};
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
    end else begin
      if (shift) begin
        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
      end
      if (bit_step) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (sclk_set) begin
        sclk_q <= 1'b1;
      end else if (fall_tick) begin
        sclk_q <= 1'b0;
      end
    end
  end

  assign sclk = sclk_q;
  assign mosi = shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_packet_spi_tx.sv
`timescale 1ns/1ps
module tb_packet_spi_tx;

  localparam int FB = 25;

  typedef struct {
    int            inst;
    logic [FB-1:0] frame;
    bit            aborted;
    int            low;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] start_v = '0;
  logic [7:0] destination = '0;
  logic [7:0] data = '0;
  logic [8:0] checkSum = '0;

  logic busy0, done0, sclk0, mosi0, csn0;
  logic busy1, done1, sclk1, mosi1, csn1;
  logic [1:0] busy_v, done_v, sclk_v, mosi_v, csn_v;

  always #5 clock = ~clock;

  packet_spi_tx #(.SIZE(8), .CLK_DIV(4)) dut (
    .clock(clock), .reset(reset), .start(start_v[0]),
    .destination(destination), .data(data), .checkSum(checkSum),
    .busy(busy0), .done(done0), .sclk(sclk0), .mosi(mosi0), .csN(csn0)
  );

  packet_spi_tx #(.SIZE(8), .CLK_DIV(1)) dut_fast (
    .clock(clock), .reset(reset), .start(start_v[1]),
    .destination(destination), .data(data), .checkSum(checkSum),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .csN(csn1)
  );

  always_comb begin
    busy_v = {busy1, busy0};
    done_v = {done1, done0};
    sclk_v = {sclk1, sclk0};
    mosi_v = {mosi1, mosi0};
    csn_v  = {csn1, csn0};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          mon_en = 1'b0;
  logic [1:0]    prev_sclk = '0;
  logic [1:0]    prev_csn = 2'b11;
  logic [FB-1:0] rx [2];
  int            rises [2];
  int            low_cnt [2];
  int            high_cnt [2];
  int            gap_seen [2];
  int            done_total = 0;
  int            sclk_cs_viol = 0;

  task automatic frame_end(input int k);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected frame end: instance %0d, no frame expected", k);
    end else begin
      e = exp_q.pop_front();
      chk("frame instance", k, e.inst);
      chk("busy at frame end", busy_v[k], 1'b0);
      if (e.aborted) begin
        chk("abort done", done_v[k], 1'b0);
        chk("abort sclk", sclk_v[k], 1'b0);
        chk("abort mosi", mosi_v[k], 1'b0);
      end else begin
        chk("frame bits", rx[k], e.frame);
        chk("sclk rises", rises[k], FB);
        chk("csN low cycles", low_cnt[k], e.low);
        chk("done at frame end", done_v[k], 1'b1);
        if (e.gap >= 0) chk("csN high gap", gap_seen[k], e.gap);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (sclk_v[k] && csn_v[k]) sclk_cs_viol++;
        if (!csn_v[k]) begin
          if (prev_csn[k]) begin
            gap_seen[k] = high_cnt[k];
            rx[k]       = '0;
            rises[k]    = 0;
            low_cnt[k]  = 0;
          end
          low_cnt[k]++;
          if (sclk_v[k] && !prev_sclk[k]) begin
            rx[k] = {rx[k][FB-2:0], mosi_v[k]};
            rises[k]++;
          end
        end else if (!prev_csn[k]) begin
          frame_end(k);
          high_cnt[k] = 1;
        end else begin
          high_cnt[k]++;
          if (done_v[k]) chk("stray done", done_v[k], 1'b0);
        end
        if (done_v[k]) done_total++;
        prev_csn[k]  = csn_v[k];
        prev_sclk[k] = sclk_v[k];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int k, input logic [7:0] d, input logic [7:0] dt,
                      input logic [8:0] cs, input logic [FB-1:0] frame,
                      input bit aborted);
    exp_t e;
    @(negedge clock);
    destination = d;
    data        = dt;
    checkSum    = cs;
    start_v[k]  = 1'b1;
    e.inst    = k;
    e.frame   = frame;
    e.aborted = aborted;
    e.low     = (k == 0) ? 208 : 52;
    e.gap     = -1;
    exp_q.push_back(e);
    @(negedge clock);
    start_v[k]  = 1'b0;
    destination = ~d;
    data        = ~dt;
    checkSum    = ~cs;
    chk("busy after start", busy_v[k], 1'b1);
    chk("csN after start", csn_v[k], 1'b0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_total < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (done_total < target) begin
      checks++;
      errors++;
      $display("FAIL done timeout: got %0d pulses, expected %0d", done_total, target);
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("reset csN", csn_v[k], 1'b1);
      chk("reset sclk", sclk_v[k], 1'b0);
      chk("reset mosi", mosi_v[k], 1'b0);
      chk("reset busy", busy_v[k], 1'b0);
      chk("reset done", done_v[k], 1'b0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reference frame; fields also change right after capture.
    send(0, 8'hA5, 8'h3C, 9'h0E1, 25'b1010_0101_0011_1100_0_1110_0001, 1'b0);
    wait_done(1, 400);

    // Re-pulsed start mid-frame must be ignored.
    send(0, 8'h12, 8'h34, 9'h155, 25'b0001_0010_0011_0100_1_0101_0101, 1'b0);
    repeat (48) @(negedge clock);
    destination = 8'hEE;
    data        = 8'hDD;
    checkSum    = 9'h0CC;
    start_v[0]  = 1'b1;
    @(negedge clock);
    start_v[0]  = 1'b0;
    chk("busy during ignored start", busy_v[0], 1'b1);
    wait_done(2, 400);
    repeat (20) @(negedge clock);
    chk("done count after ignored start", done_total, 2);

    // Reset mid-frame abandons the frame; next frame is intact.
    send(0, 8'hC3, 8'h5A, 9'h0AA, '0, 1'b1);
    repeat (98) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("csN after mid-frame reset", csn_v[0], 1'b1);
    chk("sclk after mid-frame reset", sclk_v[0], 1'b0);
    chk("mosi after mid-frame reset", mosi_v[0], 1'b0);
    reset = 1'b0;
    send(0, 8'hFF, 8'h00, 9'h1FF, 25'b1111_1111_0000_0000_1_1111_1111, 1'b0);
    wait_done(3, 400);
    chk("done count after reset test", done_total, 3);

    // start held high: three back-to-back frames with 1-cycle csN gap.
    for (int i = 0; i < 3; i++) begin
      e.inst    = 0;
      e.frame   = 25'b1000_0001_0111_1110_1_0000_0000;
      e.aborted = 1'b0;
      e.low     = 208;
      e.gap     = (i == 0) ? -1 : 1;
      exp_q.push_back(e);
    end
    @(negedge clock);
    destination = 8'h81;
    data        = 8'h7E;
    checkSum    = 9'h100;
    start_v[0]  = 1'b1;
    wait_done(5, 1000);
    @(negedge clock);
    start_v[0] = 1'b0;
    wait_done(6, 400);

    // CLK_DIV = 1: all-zero then all-one fields.
    send(1, 8'h00, 8'h00, 9'h000, 25'h0000000, 1'b0);
    wait_done(7, 200);
    send(1, 8'hFF, 8'hFF, 9'h1FF, 25'h1FFFFFF, 1'b0);
    wait_done(8, 200);

    repeat (10) @(negedge clock);
    chk("expected frames outstanding", exp_q.size(), 0);
    chk("sclk high while csN high", sclk_cs_viol, 0);
    chk("total done pulses", done_total, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
